// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 16-bit words to
// instruction memory at even addresses and releases the CPU once the checksum matches.
module prog_loader #(
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_run,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data_byte);
        return chk ^ data_byte;
    endfunction

    state_t      r_state, w_next_state;
    logic [7:0]  r_len_hi, w_len_hi;
    logic [15:0] r_len, w_len;
    logic [7:0]  r_chk, w_chk;
    logic [7:0]  r_data_hi, w_data_hi;
    logic [15:0] r_count, w_count;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_wdata, w_wdata;
    logic        r_we, w_we;
    logic        r_ready, r_run, r_done, r_error;
    logic        w_xfer;
    logic [15:0] w_rx_len;
    logic [15:0] w_count_inc;

    assign w_xfer      = rx_valid & r_ready;
    assign w_rx_len    = {r_len_hi, rx_data};
    assign w_count_inc = r_count + 16'd1;

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath decode; only an accepted byte can move the frame forward.
    always_comb begin
        w_next_state = r_state;
        w_len_hi     = r_len_hi;
        w_len        = r_len;
        w_chk        = r_chk;
        w_data_hi    = r_data_hi;
        w_count      = r_count;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_we         = 1'b0;
        if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == MAGIC) begin
                        w_next_state = S_LEN_HI;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_LEN_HI: begin
                    w_len_hi     = rx_data;
                    w_next_state = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_len = w_rx_len;
                    if ((w_rx_len == 16'd0) || (w_rx_len > MAX_LEN)) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_chk        = 8'h00;
                        w_count      = 16'd0;
                        w_next_state = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    w_data_hi    = rx_data;
                    w_chk        = chk_update(r_chk, rx_data);
                    w_next_state = S_DATA_LO;
                end
                S_DATA_LO: begin
                    w_chk   = chk_update(r_chk, rx_data);
                    w_we    = 1'b1;
                    w_addr  = {r_count[14:0], 1'b0};
                    w_wdata = {r_data_hi, rx_data};
                    w_count = w_count_inc;
                    if (w_count_inc == r_len) begin
                        w_next_state = S_CHECK;
                    end else begin
                        w_next_state = S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (rx_data == r_chk) begin
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_ERROR;
                    end
                end
                S_RUN: begin
                    w_next_state = S_RUN;
                end
                S_ERROR: begin
                    if (rx_data == MAGIC) begin
                        w_next_state = S_LEN_HI;
                    end else begin
                        w_next_state = S_ERROR;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Datapath and status registers; status flags follow the state being entered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_len_hi  <= 8'h00;
            r_len     <= 16'd0;
            r_chk     <= 8'h00;
            r_data_hi <= 8'h00;
            r_count   <= 16'd0;
            r_addr    <= 16'd0;
            r_wdata   <= 16'd0;
            r_we      <= 1'b0;
            r_ready   <= 1'b0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_len_hi  <= w_len_hi;
            r_len     <= w_len;
            r_chk     <= w_chk;
            r_data_hi <= w_data_hi;
            r_count   <= w_count;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_we      <= w_we;
            r_ready   <= (w_next_state != S_RUN);
            r_run     <= (w_next_state == S_RUN);
            r_done    <= (w_next_state == S_RUN);
            r_error   <= (w_next_state == S_ERROR);
        end
    end

    assign rx_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_run    = r_run;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as frames
// are built and compared against the writes observed on the imem port.
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_run;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    prog_loader #(.MAX_WORDS(256), .MAGIC(8'hA5)) dut (
        .CLK(CLK), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_run(cpu_run), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    // Cycle counter used to confirm stall-free streaming.
    always @(posedge CLK) cyc <= cyc + 1;

    // Capture every write strobe away from the active edge.
    always @(negedge CLK) if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata});

    task automatic send_bytes(input bq_t b, input bit gaps);
        int n;
        bit acc;
        foreach (b[i]) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
            end
            rx_valid = 1'b1;
            rx_data  = b[i];
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                acc = rx_ready;
                @(posedge CLK); #1;
                n++;
            end
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: byte %0d saw rx_ready=0 for 50 cycles, required 1", i);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic make_frame(input logic [15:0] w[$], output bq_t b);
        logic [7:0] c;
        logic [15:0] len;
        c = 8'h00;
        len = 16'(w.size());
        b = {};
        b.push_back(8'hA5); b.push_back(len[15:8]); b.push_back(len[7:0]);
        foreach (w[i]) begin
            b.push_back(w[i][15:8]); b.push_back(w[i][7:0]);
            c = c ^ w[i][15:8] ^ w[i][7:0];
        end
        b.push_back(c);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge CLK); RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        #2 RESET = 1'b0;
        #1;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", imem_we); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h required 0000", imem_addr); end
        n_checks++; if (imem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h required 0000", imem_wdata); end
        n_checks++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run: got %b required 0", cpu_run); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b required 0", error); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", rx_ready); end
    endtask

    task automatic test_nominal();
        bq_t b;
        int c0;
        logic [31:0] e, o;
        b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'h0002_ABCD);
        c0 = cyc;
        send_bytes(b, 1'b0);
        n_checks++; if ((cyc - c0) !== 8) begin n_fail++; $display("FAIL nominal_b2b_cycles: got %0d required 8", cyc - c0); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nominal_done: got %b required 1", done); end
        n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL nominal_cpu_run: got %b required 1", cpu_run); end
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL nominal_rx_ready: got %b required 0", rx_ready); end
        n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL nominal_word_count: got %0d required 2", word_count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL nominal_error: got %b required 0", error); end
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL nominal_nwrites: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL nominal_write: got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_run_lock();
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (10) begin
            @(posedge CLK); #1;
            n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL lock_rx_ready: got %b required 0", rx_ready); end
            n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL lock_cpu_run: got %b required 1", cpu_run); end
        end
        rx_valid = 1'b0;
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL lock_writes: got %0d required 0", obs_q.size()); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL lock_done: got %b required 1", done); end
    endtask

    task automatic test_bad_checksum();
        bq_t b;
        logic [31:0] e, o;
        do_reset();
        b = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h00};
        exp_q.push_back(32'h0000_BEEF);
        send_bytes(b, 1'b0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL badchk_error: got %b required 1", error); end
        n_checks++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL badchk_cpu_run: got %b required 0", cpu_run); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL badchk_done: got %b required 0", done); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL badchk_rx_ready: got %b required 1", rx_ready); end
        b = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        exp_q.push_back(32'h0000_BEEF);
        send_bytes(b, 1'b0);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL retry_error: got %b required 0", error); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL retry_done: got %b required 1", done); end
        n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL retry_cpu_run: got %b required 1", cpu_run); end
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL badchk_nwrites: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL badchk_write: got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_len_bounds();
        bq_t b;
        logic [15:0] w[$];
        logic [31:0] e, o;
        logic [15:0] last_addr;
        do_reset();
        b = '{8'hA5, 8'h00, 8'h00};
        send_bytes(b, 1'b0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len0_error: got %b required 1", error); end
        b = '{8'hA5, 8'h01, 8'h01};
        send_bytes(b, 1'b0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len257_error: got %b required 1", error); end
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL len_bad_writes: got %0d required 0", obs_q.size()); end
        for (int i = 0; i < 256; i++) begin
            w.push_back(16'($urandom));
            exp_q.push_back({16'(2 * i), w[i]});
        end
        make_frame(w, b);
        send_bytes(b, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len256_done: got %b required 1", done); end
        n_checks++; if (word_count !== 16'd256) begin n_fail++; $display("FAIL len256_word_count: got %0d required 256", word_count); end
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL len256_nwrites: got %0d required %0d", obs_q.size(), exp_q.size()); end
        last_addr = 16'hFFFF;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            last_addr = o[31:16];
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL len256_write: got %h required %h", o, e); end
        end
        n_checks++; if (last_addr !== 16'h01FE) begin n_fail++; $display("FAIL len256_last_addr: got %h required 01fe", last_addr); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_noise_gaps();
        bq_t b;
        logic [31:0] e, o;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            b = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h07};
            exp_q.push_back(32'h0000_0007);
            send_bytes(b, pass == 1);
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL noise_done pass %0d: got %b required 1", pass, done); end
            n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL noise_word_count pass %0d: got %0d required 1", pass, word_count); end
            repeat (2) begin @(posedge CLK); #1; end
            n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL noise_nwrites pass %0d: got %0d required %0d", pass, obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_checks++; if (o !== e) begin n_fail++; $display("FAIL noise_write pass %0d: got %h required %h", pass, o, e); end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_async_reset();
        bq_t b;
        logic [31:0] e, o;
        do_reset();
        b = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_bytes(b, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h34;
        #1 RESET = 1'b0;
        #1;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL areset_rx_ready: got %b required 0", rx_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL areset_we: got %b required 0", imem_we); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL areset_word_count: got %0d required 0", word_count); end
        n_checks++; if ({cpu_run, done, error} !== 3'b000) begin n_fail++; $display("FAIL areset_status: got %b required 000", {cpu_run, done, error}); end
        repeat (3) @(negedge CLK);
        rx_valid = 1'b0;
        RESET = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL areset_writes: got %0d required 0", obs_q.size()); end
        obs_q.delete();
        b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'h0002_ABCD);
        send_bytes(b, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL areset_reload_done: got %b required 1", done); end
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL areset_nwrites: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL areset_write: got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_run_lock();
        test_bad_checksum();
        test_len_bounds();
        test_noise_gaps();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
